// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB miss/refill controller.
package tlb_pkg;

    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_REQUEST  = 2'd1,
        S_WAIT     = 2'd2,
        S_WAIT_INV = 2'd3
    } tlb_state_e;

    localparam logic [1:0] PRV_U = 2'h0;
    localparam logic [1:0] PRV_S = 2'h1;

    function automatic logic [1:0] prv_encode(input logic priv_s);
        return priv_s ? PRV_S : PRV_U;
    endfunction

endpackage

// File: rtl/tlb_miss_ctrl_victim_sel.sv
// Refill victim choice: lowest invalid entry, else the round-robin pointer.
module tlb_victim_sel
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] entry_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               use_rr
);

    // Scan from the top so the lowest-index free entry is the last to win.
    always_comb begin
        idx    = rr_ptr;
        use_rr = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                idx    = IDX_W'(i);
                use_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tlb_miss_ctrl.sv
// Single-outstanding TLB miss controller: PTW request, response wait, registered refill.
// Optional performance counters are enabled with `define TLB_PERF_CNT_EN.
module tlb_miss_ctrl
    import tlb_pkg::*;
#(
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 20,
    parameter int ENTRIES = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               io_req_valid,
    input  logic [VPN_W-1:0]   io_req_bits_vpn,
    output logic               io_req_ready,
    input  logic               vm_enabled,
    input  logic               priv_s,
    input  logic               tlb_hit,
    input  logic [ENTRIES-1:0] entry_valid,
    output logic               io_resp_miss,
    output logic               io_ptw_req_valid,
    input  logic               io_ptw_req_ready,
    output logic [VPN_W-1:0]   io_ptw_req_bits_vpn,
    output logic [1:0]         io_ptw_req_bits_prv,
    input  logic               io_ptw_resp_valid,
    input  logic [PPN_W-1:0]   io_ptw_resp_bits_ppn,
    input  logic               io_ptw_invalidate,
    output logic               refill_valid,
    output logic [IDX_W-1:0]   refill_idx,
    output logic [VPN_W-1:0]   refill_vpn,
    output logic [PPN_W-1:0]   refill_ppn
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_miss_cnt,
    output logic [31:0]        perf_refill_cnt
`endif
);

    tlb_state_e       state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [1:0]       prv_q, prv_d;
    logic             refill_valid_q, refill_valid_d;
    logic [IDX_W-1:0] refill_idx_q, refill_idx_d;
    logic [VPN_W-1:0] refill_vpn_q, refill_vpn_d;
    logic [PPN_W-1:0] refill_ppn_q, refill_ppn_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] victim_idx;
    logic             victim_use_rr;
    logic             miss_start;

    tlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
        .entry_valid (entry_valid),
        .rr_ptr      (rr_ptr_q),
        .idx         (victim_idx),
        .use_rr      (victim_use_rr)
    );

    always_comb begin
        state_d        = state_q;
        vpn_d          = vpn_q;
        prv_d          = prv_q;
        refill_valid_d = 1'b0;
        refill_idx_d   = refill_idx_q;
        refill_vpn_d   = refill_vpn_q;
        refill_ppn_d   = refill_ppn_q;
        rr_ptr_d       = rr_ptr_q;
        miss_start     = 1'b0;
        unique case (state_q)
            S_READY: begin
                if (io_req_valid && vm_enabled && !tlb_hit) begin
                    vpn_d      = io_req_bits_vpn;
                    prv_d      = prv_encode(priv_s);
                    state_d    = S_REQUEST;
                    miss_start = 1'b1;
                end
            end
            // An invalidate wins over a simultaneous PTW handshake: the request is dropped.
            S_REQUEST: begin
                if (io_ptw_invalidate) begin
                    state_d = S_READY;
                end else if (io_ptw_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_ptw_resp_valid) begin
                    state_d = S_READY;
                    if (!io_ptw_invalidate) begin
                        refill_valid_d = 1'b1;
                        refill_idx_d   = victim_idx;
                        refill_vpn_d   = vpn_q;
                        refill_ppn_d   = io_ptw_resp_bits_ppn;
                        if (victim_use_rr) begin
                            rr_ptr_d = (rr_ptr_q == IDX_W'(ENTRIES - 1)) ? '0
                                                                        : rr_ptr_q + IDX_W'(1);
                        end
                    end
                end else if (io_ptw_invalidate) begin
                    state_d = S_WAIT_INV;
                end
            end
            S_WAIT_INV: begin
                if (io_ptw_resp_valid) begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_READY;
            vpn_q          <= '0;
            prv_q          <= '0;
            refill_valid_q <= 1'b0;
            refill_idx_q   <= '0;
            refill_vpn_q   <= '0;
            refill_ppn_q   <= '0;
            rr_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            vpn_q          <= vpn_d;
            prv_q          <= prv_d;
            refill_valid_q <= refill_valid_d;
            refill_idx_q   <= refill_idx_d;
            refill_vpn_q   <= refill_vpn_d;
            refill_ppn_q   <= refill_ppn_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign io_req_ready        = (state_q == S_READY);
    assign io_ptw_req_valid    = (state_q == S_REQUEST);
    assign io_resp_miss        = io_req_valid & ((state_q != S_READY) | (vm_enabled & ~tlb_hit));
    assign io_ptw_req_bits_vpn = vpn_q;
    assign io_ptw_req_bits_prv = prv_q;
    assign refill_valid        = refill_valid_q;
    assign refill_idx          = refill_idx_q;
    assign refill_vpn          = refill_vpn_q;
    assign refill_ppn          = refill_ppn_q;

`ifdef TLB_PERF_CNT_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] refill_cnt_q, refill_cnt_d;

    always_comb begin
        miss_cnt_d   = miss_cnt_q + {31'd0, miss_start};
        refill_cnt_d = refill_cnt_q + {31'd0, refill_valid_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_q   <= '0;
            refill_cnt_q <= '0;
        end else begin
            miss_cnt_q   <= miss_cnt_d;
            refill_cnt_q <= refill_cnt_d;
        end
    end

    assign perf_miss_cnt   = miss_cnt_q;
    assign perf_refill_cnt = refill_cnt_q;
`else
    logic unused_miss_start;
    assign unused_miss_start = miss_start;
`endif

endmodule
